// File: rtl/uc_coordena_asteroides_tiros_pkg.sv
// Shared definitions for the asteroid/shot tick sequencer: state codes and default widths.
package uc_coordena_asteroides_tiros_pkg;

    localparam int unsigned LARG_END_AST_PADRAO  = 4;
    localparam int unsigned LARG_END_TIRO_PADRAO = 3;
    localparam int unsigned LARG_ESTADO          = 4;

    // Debug code shown when the state register holds an unused encoding.
    localparam logic [LARG_ESTADO-1:0] DB_INVALIDO = 4'hF;

    typedef enum logic [LARG_ESTADO-1:0] {
        INICIAL       = 4'd0,
        ESPERA        = 4'd1,
        LE_AST        = 4'd2,
        ATUALIZA_AST  = 4'd3,
        LE_TIRO       = 4'd4,
        ATUALIZA_TIRO = 4'd5,
        LE_PAR        = 4'd6,
        COMPARA       = 4'd7,
        FIM           = 4'd8
    } estado_t;

endpackage

// File: rtl/uc_coordena_asteroides_tiros_contador_indices.sv
// Two-level index counter: i_ast (inner) and i_tiro (outer) with clear, increment and last-index flags.
module contador_indices #(
    parameter int unsigned LARG_AST  = 4,
    parameter int unsigned LARG_TIRO = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 limpa,
    input  logic                 limpa_ast,
    input  logic                 inc_ast,
    input  logic                 inc_tiro,
    output logic [LARG_AST-1:0]  i_ast,
    output logic [LARG_AST-1:0]  i_ast_prox,
    output logic [LARG_TIRO-1:0] i_tiro,
    output logic [LARG_TIRO-1:0] i_tiro_prox,
    output logic                 ast_ultimo,
    output logic                 tiro_ultimo
);

    logic [LARG_AST-1:0]  i_ast_q;
    logic [LARG_AST-1:0]  i_ast_d;
    logic [LARG_TIRO-1:0] i_tiro_q;
    logic [LARG_TIRO-1:0] i_tiro_d;

    // Next index values; a full clear wins over everything, increments wrap naturally.
    always_comb begin
        i_ast_d  = i_ast_q;
        i_tiro_d = i_tiro_q;
        if (limpa) begin
            i_ast_d  = '0;
            i_tiro_d = '0;
        end else begin
            if (limpa_ast) begin
                i_ast_d = '0;
            end else if (inc_ast) begin
                i_ast_d = i_ast_q + LARG_AST'(1);
            end
            if (inc_tiro) begin
                i_tiro_d = i_tiro_q + LARG_TIRO'(1);
            end
        end
    end

    // Index registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_ast_q  <= '0;
            i_tiro_q <= '0;
        end else begin
            i_ast_q  <= i_ast_d;
            i_tiro_q <= i_tiro_d;
        end
    end

    assign i_ast       = i_ast_q;
    assign i_ast_prox  = i_ast_d;
    assign i_tiro      = i_tiro_q;
    assign i_tiro_prox = i_tiro_d;
    assign ast_ultimo  = (i_ast_q == '1);
    assign tiro_ultimo = (i_tiro_q == '1);

endmodule

// File: rtl/uc_coordena_asteroides_tiros.sv
// Control unit for one game tick: asteroid sweep, shot sweep, then shot x asteroid collision sweep.
// Addresses are registered and change on entry to the LE_* states, so the synchronous memory
// read issued in LE_* is valid in the following ATUALIZA_*/COMPARA cycle. Strobes are decoded
// from the current state and that cycle's datapath flags so they line up with the held address.
module uc_coordena_asteroides_tiros
    import uc_coordena_asteroides_tiros_pkg::*;
#(
    parameter int unsigned LARG_END_AST  = LARG_END_AST_PADRAO,
    parameter int unsigned LARG_END_TIRO = LARG_END_TIRO_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic                     asteroide_ativo,
    input  logic                     tiro_ativo,
    input  logic                     asteroide_na_nave,
    input  logic                     tiro_fora_tela,
    input  logic                     colisao,
    output logic [LARG_END_AST-1:0]  end_asteroide,
    output logic [LARG_END_TIRO-1:0] end_tiro,
    output logic                     move_asteroide,
    output logic                     move_tiro,
    output logic                     desativa_asteroide,
    output logic                     desativa_tiro,
    output logic                     perde_vida,
    output logic                     pontua,
    output logic                     pronto,
    output logic [LARG_ESTADO-1:0]   db_estado
);

    estado_t                  state_q;
    estado_t                  state_d;

    logic                     limpa;
    logic                     limpa_ast;
    logic                     inc_ast;
    logic                     inc_tiro;

    logic [LARG_END_AST-1:0]  i_ast;
    logic [LARG_END_AST-1:0]  i_ast_prox;
    logic [LARG_END_TIRO-1:0] i_tiro;
    logic [LARG_END_TIRO-1:0] i_tiro_prox;
    logic                     ast_ultimo;
    logic                     tiro_ultimo;

    logic [LARG_END_AST-1:0]  end_ast_q;
    logic [LARG_END_AST-1:0]  end_ast_d;
    logic [LARG_END_TIRO-1:0] end_tiro_q;
    logic [LARG_END_TIRO-1:0] end_tiro_d;
    logic                     pronto_q;
    logic                     pronto_d;

    contador_indices #(
        .LARG_AST  (LARG_END_AST),
        .LARG_TIRO (LARG_END_TIRO)
    ) u_contador (
        .clock       (clock),
        .reset       (reset),
        .limpa       (limpa),
        .limpa_ast   (limpa_ast),
        .inc_ast     (inc_ast),
        .inc_tiro    (inc_tiro),
        .i_ast       (i_ast),
        .i_ast_prox  (i_ast_prox),
        .i_tiro      (i_tiro),
        .i_tiro_prox (i_tiro_prox),
        .ast_ultimo  (ast_ultimo),
        .tiro_ultimo (tiro_ultimo)
    );

    // Next state, counter controls, strobes and debug code.
    always_comb begin
        state_d            = state_q;
        limpa              = 1'b0;
        limpa_ast          = 1'b0;
        inc_ast            = 1'b0;
        inc_tiro           = 1'b0;
        move_asteroide     = 1'b0;
        move_tiro          = 1'b0;
        desativa_asteroide = 1'b0;
        desativa_tiro      = 1'b0;
        perde_vida         = 1'b0;
        pontua             = 1'b0;
        db_estado          = LARG_ESTADO'(state_q);

        case (state_q)
            INICIAL: begin
                state_d = ESPERA;
            end

            ESPERA: begin
                if (iniciar) begin
                    limpa   = 1'b1;
                    state_d = LE_AST;
                end
            end

            LE_AST: begin
                state_d = ATUALIZA_AST;
            end

            ATUALIZA_AST: begin
                if (asteroide_ativo) begin
                    move_asteroide = 1'b1;
                    if (asteroide_na_nave) begin
                        desativa_asteroide = 1'b1;
                        perde_vida         = 1'b1;
                    end
                end
                inc_ast = 1'b1;
                state_d = ast_ultimo ? LE_TIRO : LE_AST;
            end

            LE_TIRO: begin
                state_d = ATUALIZA_TIRO;
            end

            ATUALIZA_TIRO: begin
                if (tiro_ativo) begin
                    if (tiro_fora_tela) begin
                        desativa_tiro = 1'b1;
                    end else begin
                        move_tiro = 1'b1;
                    end
                end
                inc_tiro = 1'b1;
                if (tiro_ultimo) begin
                    limpa_ast = 1'b1;
                    state_d   = LE_PAR;
                end else begin
                    state_d = LE_TIRO;
                end
            end

            LE_PAR: begin
                state_d = COMPARA;
            end

            COMPARA: begin
                if (!tiro_ativo) begin
                    // Nothing to test for an empty shot slot.
                    inc_tiro  = 1'b1;
                    limpa_ast = 1'b1;
                end else if (asteroide_ativo && colisao) begin
                    // A shot is spent on its first hit.
                    desativa_asteroide = 1'b1;
                    desativa_tiro      = 1'b1;
                    pontua             = 1'b1;
                    inc_tiro           = 1'b1;
                    limpa_ast          = 1'b1;
                end else begin
                    inc_ast  = 1'b1;
                    inc_tiro = ast_ultimo;
                end
                state_d = (inc_tiro && tiro_ultimo) ? FIM : LE_PAR;
            end

            FIM: begin
                limpa   = 1'b1;
                state_d = ESPERA;
            end

            default: begin
                state_d   = INICIAL;
                db_estado = DB_INVALIDO;
            end
        endcase
    end

    // Address and done registers load from the state being entered.
    always_comb begin
        end_ast_d  = end_ast_q;
        end_tiro_d = end_tiro_q;
        pronto_d   = (state_d == FIM);
        if ((state_d == LE_AST) || (state_d == LE_PAR)) begin
            end_ast_d = i_ast_prox;
        end
        if ((state_d == LE_TIRO) || (state_d == LE_PAR)) begin
            end_tiro_d = i_tiro_prox;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= INICIAL;
            end_ast_q  <= '0;
            end_tiro_q <= '0;
            pronto_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            end_ast_q  <= end_ast_d;
            end_tiro_q <= end_tiro_d;
            pronto_q   <= pronto_d;
        end
    end

    assign end_asteroide = end_ast_q;
    assign end_tiro      = end_tiro_q;
    assign pronto        = pronto_q;

endmodule
